// File: rtl/game_binary_entry.sv
// Binary-entry quiz: show a random digit, the player keys its binary pattern MSB-first.
// Optional ENTRY_TIMEOUT_EN macro: abandon an idle entry after TIMEOUT_TIME cycles.

module random_digit (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rnd
);

  // Free-running 0..9 counter; sampling it at a human button press makes it unpredictable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rnd <= 4'd0;
    else       rnd <= (rnd == 4'd9) ? 4'd0 : rnd + 4'd1;
  end

endmodule

module game_binary_entry #(
  parameter int NUM_BITS     = 3,
  parameter int COUNTER_LEN  = 26,
  parameter int DELAY_TIME   = 10_000_000,
  parameter int TIMEOUT_TIME = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  output logic [3:0] value
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  localparam logic [3:0] CODE_CORRECT  = 4'd10;
  localparam logic [3:0] CODE_ERROR    = 4'd11;
  localparam logic [3:0] CODE_BLANK    = 4'd12;
  localparam logic [3:0] CODE_QUESTION = 4'd13;

  localparam logic [COUNTER_LEN-1:0] DELAY_LIMIT = COUNTER_LEN'(DELAY_TIME);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SHOW_TARGET,
    S_ENTER,
    S_RESULT
  } state_t;

  state_t                  state_q, state_nxt;
  logic [3:0]              value_nxt;
  logic [NUM_BITS-1:0]     target_q, target_nxt;
  logic [NUM_BITS-1:0]     entry_q, entry_nxt;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_nxt;
  logic [COUNTER_LEN-1:0]  counter_q, counter_nxt;
  logic [3:0]              prev_q;
  logic [3:0]              btn_vec;
  logic [3:0]              press;
  logic [3:0]              rnd;
  logic                    rnd_unused;

  random_digit u_random_digit (
    .clk   (clk),
    .reset (reset),
    .rnd   (rnd)
  );

  assign rnd_unused = ^rnd[3:NUM_BITS];

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [COUNTER_LEN-1:0] TIMEOUT_LIMIT = COUNTER_LEN'(TIMEOUT_TIME);
`else
  localparam int timeout_unused = TIMEOUT_TIME;
`endif

  assign btn_vec = {btn4, btn3, btn2, btn1};
  assign press   = btn_vec & ~prev_q;

  // Bit keyed this cycle: btn1 outranks btn2, so a simultaneous pair enters 0.
  logic                bit_valid;
  logic                bit_in;
  logic [NUM_BITS:0]   shift_wide;
  logic [NUM_BITS-1:0] entry_shifted;
  logic [CNT_W-1:0]    bit_cnt_inc;

  assign bit_valid     = press[0] | press[1];
  assign bit_in        = ~press[0];
  assign shift_wide    = {entry_q, bit_in};
  assign entry_shifted = shift_wide[NUM_BITS-1:0];
  assign bit_cnt_inc   = bit_cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every always_comb output takes its hold value first so no path infers a latch.
    state_nxt   = state_q;
    value_nxt   = value;
    target_nxt  = target_q;
    entry_nxt   = entry_q;
    bit_cnt_nxt = bit_cnt_q;
    counter_nxt = counter_q;

    case (state_q)
      S_WAIT: begin
        value_nxt   = CODE_BLANK;
        counter_nxt = '0;
        if (|press) begin
          target_nxt  = rnd[NUM_BITS-1:0];
          entry_nxt   = '0;
          bit_cnt_nxt = '0;
          value_nxt   = 4'(rnd[NUM_BITS-1:0]);
          state_nxt   = S_SHOW_TARGET;
        end
      end

      S_SHOW_TARGET: begin
        if (counter_q >= DELAY_LIMIT) begin
          counter_nxt = '0;
          value_nxt   = CODE_QUESTION;
          state_nxt   = S_ENTER;
        end else begin
          counter_nxt = counter_q + COUNTER_LEN'(1);
        end
      end

      S_ENTER: begin
        if (bit_valid) begin
          entry_nxt   = entry_shifted;
          bit_cnt_nxt = bit_cnt_inc;
          counter_nxt = '0;
          if (bit_cnt_inc == CNT_W'(NUM_BITS)) begin
            value_nxt = (entry_shifted == target_q) ? CODE_CORRECT : CODE_ERROR;
            state_nxt = S_RESULT;
          end else begin
            value_nxt = {3'b000, bit_in};
          end
        end else if (press[2]) begin
          entry_nxt   = '0;
          bit_cnt_nxt = '0;
          counter_nxt = '0;
          value_nxt   = CODE_QUESTION;
        end else begin
`ifdef ENTRY_TIMEOUT_EN
          if (counter_q >= TIMEOUT_LIMIT) begin
            counter_nxt = '0;
            value_nxt   = CODE_ERROR;
            state_nxt   = S_RESULT;
          end else begin
            counter_nxt = counter_q + COUNTER_LEN'(1);
          end
`else
          counter_nxt = '0;
`endif
        end
      end

      S_RESULT: begin
        if (counter_q >= DELAY_LIMIT) begin
          counter_nxt = '0;
          value_nxt   = CODE_BLANK;
          state_nxt   = S_WAIT;
        end else begin
          counter_nxt = counter_q + COUNTER_LEN'(1);
        end
      end

      default: begin
        counter_nxt = '0;
        value_nxt   = CODE_BLANK;
        state_nxt   = S_WAIT;
      end
    endcase
  end

  // Previous-button registers reset high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_WAIT;
      value     <= CODE_BLANK;
      target_q  <= '0;
      entry_q   <= '0;
      bit_cnt_q <= '0;
      counter_q <= '0;
      prev_q    <= '1;
    end else begin
      state_q   <= state_nxt;
      value     <= value_nxt;
      target_q  <= target_nxt;
      entry_q   <= entry_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      counter_q <= counter_nxt;
      prev_q    <= btn_vec;
    end
  end

endmodule
